// File: rtl/pipelined_adder.sv
// Purpose: pipelined ripple-carry add/subtract, one SEG-bit segment rippled per stage, with carry-out and signed overflow.
// Latency: NSTAGE = WIDTH/SEG enabled cycles from in_valid sample to out_valid; one operation per cycle.
// Backpressure: none beyond en; en=0 freezes every register, and results must be taken whenever en=1 and out_valid=1.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int NSTAGE = WIDTH / SEG;

    // A partial last segment would leave high bits unadded, so refuse to build it.
    if (WIDTH % SEG != 0) begin : g_seg_check
        $error("pipelined_adder: WIDTH must be an integer multiple of SEG");
    end

    // One segment of full-adder cells. Returns {carry into segment MSB, carry out, sum}.
    function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic           ci);
        logic [SEG:0]   c;
        logic [SEG-1:0] s;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (b[i] & c[i]) | (c[i] & a[i]);
        end
        return {c[SEG-1], c[SEG], s};
    endfunction

    // Subtract is A + ~B + 1; resolved once here so later stages only ever add.
    logic [WIDTH-1:0] w_beff;
    logic             w_c0;
    assign w_beff = sub ? ~B : B;
    assign w_c0   = sub | Cin;

    // Per-stage registers. Operands travel whole words so segment k is k stages late
    // when used; the partial sum travels too, so finished low segments wait for the top.
    logic [WIDTH-1:0] r_a   [NSTAGE];
    logic [WIDTH-1:0] r_b   [NSTAGE];
    logic [WIDTH-1:0] r_sum [NSTAGE];
    logic             r_c   [NSTAGE];
    logic             r_v   [NSTAGE];
    logic             r_cmsb;

    // Stage inputs and stage combinational results.
    logic [WIDTH-1:0] w_in_a   [NSTAGE];
    logic [WIDTH-1:0] w_in_b   [NSTAGE];
    logic [WIDTH-1:0] w_in_sum [NSTAGE];
    logic             w_in_c   [NSTAGE];
    logic             w_in_v   [NSTAGE];
    logic [WIDTH-1:0] w_nsum   [NSTAGE];
    logic             w_cout   [NSTAGE];
    logic             w_cmsb   [NSTAGE];
    logic [SEG-1:0]   w_seg;

    // Route each stage's inputs (stage 0 from the ports) and ripple its own segment.
    always_comb begin
        w_seg       = '0;
        w_in_a[0]   = A;
        w_in_b[0]   = w_beff;
        w_in_sum[0] = '0;
        w_in_c[0]   = w_c0;
        w_in_v[0]   = in_valid;
        for (int s = 1; s < NSTAGE; s++) begin
            w_in_a[s]   = r_a[s-1];
            w_in_b[s]   = r_b[s-1];
            w_in_sum[s] = r_sum[s-1];
            w_in_c[s]   = r_c[s-1];
            w_in_v[s]   = r_v[s-1];
        end
        for (int s = 0; s < NSTAGE; s++) begin
            {w_cmsb[s], w_cout[s], w_seg} = seg_add(w_in_a[s][s*SEG +: SEG],
                                                    w_in_b[s][s*SEG +: SEG],
                                                    w_in_c[s]);
            w_nsum[s]                 = w_in_sum[s];
            w_nsum[s][s*SEG +: SEG]   = w_seg;
        end
    end

    // Advance the whole pipeline on enable; reset wipes in-flight operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSTAGE; s++) begin
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
                r_v[s]   <= 1'b0;
            end
            r_cmsb <= 1'b0;
        end else if (en) begin
            for (int s = 0; s < NSTAGE; s++) begin
                r_a[s]   <= w_in_a[s];
                r_b[s]   <= w_in_b[s];
                r_sum[s] <= w_nsum[s];
                r_c[s]   <= w_cout[s];
                r_v[s]   <= w_in_v[s];
            end
            // Only the last stage's carry into its MSB is the word's carry into bit WIDTH-1.
            r_cmsb <= w_cmsb[NSTAGE-1];
        end
    end

    logic             r_out_v;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_c;
    logic             r_out_ovf;

    // Result registers load only on a valid completion, so bubbles leave the last result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v   <= 1'b0;
            r_out_sum <= '0;
            r_out_c   <= 1'b0;
            r_out_ovf <= 1'b0;
        end else if (en) begin
            r_out_v <= r_v[NSTAGE-1];
            if (r_v[NSTAGE-1]) begin
                r_out_sum <= r_sum[NSTAGE-1];
                r_out_c   <= r_c[NSTAGE-1];
                r_out_ovf <= r_cmsb ^ r_c[NSTAGE-1];
            end
        end
    end

    assign out_valid = r_out_v;
    assign Sum       = r_out_sum;
    assign Cout      = r_out_c;
    assign Ovf       = r_out_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Purpose: self-checking bench for pipelined_adder at 16/4, 16/16 and 32/8 against an arithmetic model.
// Latency: expects results NSTAGE enabled edges after capture; stalled edges do not count.
// Backpressure: drives en stalls and bubbles; the model freezes expectations whenever en=0.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst, en, in_valid, sub, Cin;
    logic [31:0] A32, B32;

    logic        v0, v1, v2, c0, c1, c2, f0, f1, f2;
    logic [15:0] s0, s1;
    logic [31:0] s2;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .SEG(4)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
        .A(A32[15:0]), .B(B32[15:0]), .Cin(Cin),
        .out_valid(v0), .Sum(s0), .Cout(c0), .Ovf(f0));

    pipelined_adder #(.WIDTH(16), .SEG(16)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
        .A(A32[15:0]), .B(B32[15:0]), .Cin(Cin),
        .out_valid(v1), .Sum(s1), .Cout(c1), .Ovf(f1));

    pipelined_adder #(.WIDTH(32), .SEG(8)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
        .A(A32), .B(B32), .Cin(Cin),
        .out_valid(v2), .Sum(s2), .Cout(c2), .Ovf(f2));

    localparam int WD  [3] = '{16, 16, 32};
    localparam int LAT [3] = '{4, 1, 4};

    logic        o_v [3];
    logic [31:0] o_s [3];
    logic        o_c [3];
    logic        o_o [3];
    assign o_v[0] = v0;  assign o_s[0] = {16'h0, s0};  assign o_c[0] = c0;  assign o_o[0] = f0;
    assign o_v[1] = v1;  assign o_s[1] = {16'h0, s1};  assign o_c[1] = c1;  assign o_o[1] = f1;
    assign o_v[2] = v2;  assign o_s[2] = s2;           assign o_c[2] = c2;  assign o_o[2] = f2;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning. Returns {ovf, cout, sum}.
    function automatic logic [33:0] model(input int w, input logic s, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        longint lim, ua, ub, sa, sb, t, r;
        logic   co, ov;
        lim = longint'(1) << w;
        ua  = longint'(a) & (lim - 1);
        ub  = longint'(b) & (lim - 1);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
        if (s) begin
            t  = ua - ub;
            co = (ua >= ub);
            r  = sa - sb;
        end else begin
            t  = ua + ub + longint'(c);
            co = (t >= lim);
            r  = sa + sb + longint'(c);
        end
        ov = (r >= lim / 2) || (r < -(lim / 2));
        return {ov, co, 32'(t & (lim - 1))};
    endfunction

    // Scoreboard: the operation captured at enabled edge m appears after enabled edge m+LAT.
    logic        hv [3][4096];
    logic [33:0] hr [3][4096];
    int          ecnt [3];
    logic        exp_v [3];
    logic [33:0] exp_r [3];
    logic        sb_on = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                ecnt[d]  <= 0;
                exp_v[d] <= 1'b0;
                exp_r[d] <= '0;
            end else if (en) begin
                hv[d][ecnt[d] % 4096] <= in_valid;
                hr[d][ecnt[d] % 4096] <= model(WD[d], sub,
                                               (d < 2) ? {16'h0, A32[15:0]} : A32,
                                               (d < 2) ? {16'h0, B32[15:0]} : B32, Cin);
                if (ecnt[d] >= LAT[d] && hv[d][(ecnt[d] - LAT[d]) % 4096]) begin
                    exp_v[d] <= 1'b1;
                    exp_r[d] <= hr[d][(ecnt[d] - LAT[d]) % 4096];
                end else begin
                    exp_v[d] <= 1'b0;
                end
                ecnt[d] <= ecnt[d] + 1;
            end
        end
        sb_on <= 1'b1;
    end

    // Every cycle, every instance's outputs must match the model.
    always @(negedge clk) begin
        if (sb_on) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d_out_valid", d), longint'(o_v[d]), longint'(exp_v[d]));
                chk($sformatf("d%0d_sum", d), longint'(o_s[d]), longint'(exp_r[d][31:0]));
                chk($sformatf("d%0d_cout", d), longint'(o_c[d]), longint'(exp_r[d][32]));
                chk($sformatf("d%0d_ovf", d), longint'(o_o[d]), longint'(exp_r[d][33]));
            end
        end
    end

    typedef struct {
        logic [15:0] a, b;
        logic        sub, cin;
        logic [15:0] sum;
        logic        cout, ovf;
    } vec_t;

    vec_t tv [8];

    task automatic rand_ops();
        A32 = $urandom;
        B32 = $urandom;
        sub = 1'($urandom % 2);
        Cin = 1'($urandom % 2);
    endtask

    // Stimulus: reset, directed table, 32-bit ripple, stall, reset mid-flight, random streaming.
    initial begin
        int lat0, lat1, lat2, first, nres, nops;
        logic [15:0] g0s, g1s;
        logic        g0c, g0o;

        tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[1] = '{16'h0FFF, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0};
        tv[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tv[3] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tv[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        tv[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[7] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};

        // Reset held two edges with live random operations offered.
        rst = 1'b1; en = 1'b1; in_valid = 1'b1;
        rand_ops();
        repeat (2) begin
            @(negedge clk);
            rand_ops();
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Directed table: one operation, then bubbles until the results show.
        for (int i = 0; i < 8; i++) begin
            A32 = {16'h0, tv[i].a}; B32 = {16'h0, tv[i].b};
            sub = tv[i].sub; Cin = tv[i].cin; in_valid = 1'b1;
            lat0 = -1; lat1 = -1;
            g0s = '0; g0c = 1'b0; g0o = 1'b0; g1s = '0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                if (v0 && lat0 < 0) begin lat0 = k - 1; g0s = s0; g0c = c0; g0o = f0; end
                if (v1 && lat1 < 0) begin lat1 = k - 1; g1s = s1; end
            end
            chk($sformatf("vec%0d_lat_16x4", i), lat0, 4);
            chk($sformatf("vec%0d_lat_16x16", i), lat1, 1);
            chk($sformatf("vec%0d_sum", i), g0s, tv[i].sum);
            chk($sformatf("vec%0d_cout", i), g0c, tv[i].cout);
            chk($sformatf("vec%0d_ovf", i), g0o, tv[i].ovf);
            chk($sformatf("vec%0d_sum_16x16", i), g1s, tv[i].sum);
        end

        // Full 32-bit carry ripple through four 8-bit stages.
        A32 = 32'hFFFF_FFFF; B32 = 32'h0000_0001; sub = 1'b0; Cin = 1'b0; in_valid = 1'b1;
        lat2 = -1; nres = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (v2 && lat2 < 0) begin
                lat2 = k - 1;
                chk("rip32_sum", s2, 0);
                chk("rip32_cout", c2, 1);
                chk("rip32_ovf", f2, 0);
            end
        end
        chk("rip32_lat", lat2, 4);

        // Stall: three ops, en low for three edges (offered inputs must be ignored).
        first = -1; nres = 0;
        for (int i = 0; i < 14; i++) begin
            rand_ops();
            en       = !(i >= 3 && i <= 5);
            in_valid = (i <= 5);
            @(negedge clk);
            if (en && v0) begin
                nres++;
                if (first < 0) first = i;
            end
        end
        chk("stall_first_result_edge", first, 7);
        chk("stall_result_count", nres, 3);

        // Reset with three operations in flight: nothing may emerge afterwards.
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops(); in_valid = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1; rand_ops();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; nres = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (v0 || v1 || v2) nres++;
        end
        chk("rst_midflight_stale", nres, 0);

        // Streaming with bubbles, then with random stalls too.
        nops = 0;
        while (nops < 1000) begin
            rand_ops();
            in_valid = ($urandom % 4) != 0;
            en = 1'b1;
            if (in_valid) nops++;
            @(negedge clk);
        end
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            in_valid = ($urandom % 4) != 0;
            en = ($urandom % 4) != 0;
            @(negedge clk);
        end
        en = 1'b1; in_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop if the run ever wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
